// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-side operands/controls, mem_stage probe, and the
// registered bundle ex_stage hands to mem_stage. master drives, slave is ex_stage.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            we;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [XLEN-1:0] pc_next;
  logic            is_branch_in;
  logic            mem_read_in;
  logic            mem_write_in;
  logic            mem_type_in;
  logic            mem_to_reg_in;
  logic            reg_write_in;
  logic [4:0]      reg_addr_in;
  logic [4:0]      reg_probe;
  logic [XLEN-1:0] data_probe;
  logic            write_probe;
  logic            stall;
  logic            is_branch;
  logic            mem_read;
  logic            mem_write;
  logic            mem_type;
  logic            mem_to_reg;
  logic            reg_write;
  logic [XLEN-1:0] pc_branch;
  logic            alu_zero;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] data_t;
  logic [4:0]      reg_addr;

  modport master (
    output we, alu_op, src_a, src_b,
    output rs_addr, rt_addr, imm, use_imm,
    output pc_next, is_branch_in,
    output mem_read_in, mem_write_in,
    output mem_type_in, mem_to_reg_in,
    output reg_write_in, reg_addr_in,
    output reg_probe, data_probe,
    output write_probe,
    input  stall, is_branch, mem_read,
    input  mem_write, mem_type,
    input  mem_to_reg, reg_write,
    input  pc_branch, alu_zero, alu_out,
    input  data_t, reg_addr
  );

  modport slave (
    input  we, alu_op, src_a, src_b,
    input  rs_addr, rt_addr, imm, use_imm,
    input  pc_next, is_branch_in,
    input  mem_read_in, mem_write_in,
    input  mem_type_in, mem_to_reg_in,
    input  reg_write_in, reg_addr_in,
    input  reg_probe, data_probe,
    input  write_probe,
    output stall, is_branch, mem_read,
    output mem_write, mem_type,
    output mem_to_reg, reg_write,
    output pc_branch, alu_zero, alu_out,
    output data_t, reg_addr
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: forwarding, single-cycle ALU, iterative MUL/DIVU/REMU, branch target.
// Optional mul/div unit compiled in with EX_MULDIV_EN.
module ex_stage #(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave ex
);

  // only one iteration per operand bit is supported
  if (MD_ITERS != XLEN) begin : g_iters_ne_xlen
  end

  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res_d;
  logic [4:0]      sh;
  logic            stall;

  logic            is_branch_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            mem_type_q;
  logic            mem_to_reg_q;
  logic            reg_write_q;
  logic [XLEN-1:0] pc_branch_q;
  logic            alu_zero_q;
  logic [XLEN-1:0] alu_out_q;
  logic [XLEN-1:0] data_t_q;
  logic [4:0]      reg_addr_q;

  // operand forwarding from mem_stage; r0 never forwards
  always_comb begin
    fa = ex.src_a;
    fb = ex.src_b;
    if (ex.write_probe && ex.reg_probe != '0 &&
        ex.reg_probe == ex.rs_addr)
      fa = ex.data_probe;
    if (ex.write_probe && ex.reg_probe != '0 &&
        ex.reg_probe == ex.rt_addr)
      fb = ex.data_probe;
    opb = ex.use_imm ? ex.imm : fb;
  end

  assign sh = opb[4:0];

  // single-cycle ALU; unused encodings and mul/div give 0
  always_comb begin
    alu_res = '0;
    case (ex.alu_op)
      4'd0:    alu_res = fa + opb;
      4'd1:    alu_res = fa - opb;
      4'd2:    alu_res = fa & opb;
      4'd3:    alu_res = fa | opb;
      4'd4:    alu_res = fa ^ opb;
      4'd5:    alu_res = ~(fa | opb);
      4'd6:    alu_res = {{(XLEN-1){1'b0}},
                          ($signed(fa) < $signed(opb))};
      4'd7:    alu_res = fa << sh;
      4'd8:    alu_res = fa >> sh;
      4'd9:    alu_res = $signed(fa) >>> sh;
      4'd10:   alu_res = opb << 16;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  localparam int CW = $clog2(MD_ITERS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] md_res;
  logic [XLEN:0]   rem_sh;
  logic            div_q;
  logic            is_md;

  assign is_md = ex.alu_op inside {4'd12, 4'd13, 4'd14};
  assign stall = !reset &&
                 ((state_q == IDLE && is_md) ||
                  state_q == BUSY);

  // one shift-add (mul) or restoring-divide step;
  // a_q doubles as multiplicand or dividend/quotient
  always_comb begin
    rem_sh = {acc_q, a_q[XLEN-1]};
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, b_q}) begin
        acc_d = rem_sh[XLEN-1:0] - b_q;
        a_d   = {a_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[XLEN-1:0];
        a_d   = {a_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end
  end

  assign md_res = (ex.alu_op == 4'd13) ? a_q : acc_q;
  assign res_d  = (state_q == DONE) ? md_res : alu_res;

  // mul/div sequencer: latch operands, iterate, hand result to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
    end else if (ex.we) begin
      unique case (state_q)
        IDLE: begin
          if (is_md) begin
            a_q     <= fa;
            b_q     <= opb;
            acc_q   <= '0;
            cnt_q   <= '0;
            div_q   <= (ex.alu_op != 4'd12);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(MD_ITERS - 1))
            state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign stall = 1'b0;
  assign res_d = alu_res;
`endif

  // register toward mem_stage; stalled edges insert a control bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_branch_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_type_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_branch_q  <= '0;
      alu_zero_q   <= 1'b0;
      alu_out_q    <= '0;
      data_t_q     <= '0;
      reg_addr_q   <= '0;
    end else if (ex.we) begin
      if (stall) begin
        is_branch_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        mem_type_q   <= 1'b0;
        mem_to_reg_q <= 1'b0;
        reg_write_q  <= 1'b0;
      end else begin
        is_branch_q  <= ex.is_branch_in;
        mem_read_q   <= ex.mem_read_in;
        mem_write_q  <= ex.mem_write_in;
        mem_type_q   <= ex.mem_type_in;
        mem_to_reg_q <= ex.mem_to_reg_in;
        reg_write_q  <= ex.reg_write_in;
        pc_branch_q  <= ex.pc_next + (ex.imm << 2);
        alu_zero_q   <= (res_d == '0);
        alu_out_q    <= res_d;
        data_t_q     <= fb;
        reg_addr_q   <= ex.reg_addr_in;
      end
    end
  end

  assign ex.stall      = stall;
  assign ex.is_branch  = is_branch_q;
  assign ex.mem_read   = mem_read_q;
  assign ex.mem_write  = mem_write_q;
  assign ex.mem_type   = mem_type_q;
  assign ex.mem_to_reg = mem_to_reg_q;
  assign ex.reg_write  = reg_write_q;
  assign ex.pc_branch  = pc_branch_q;
  assign ex.alu_zero   = alu_zero_q;
  assign ex.alu_out    = alu_out_q;
  assign ex.data_t     = data_t_q;
  assign ex.reg_addr   = reg_addr_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random + directed stimulus for ex_stage, checked every
// cycle against an instruction-level reference model.
module tb_ex_stage;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if #(.XLEN(32)) ex ();

  ex_stage #(
    .XLEN    (32),
    .MD_ITERS(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ex   (ex)
  );

  always #5 clk = ~clk;

`ifdef EX_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif
  // cycles an iterative op keeps upstream stalled
  localparam int MD_CYC = 33;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pcn;
    logic [31:0] dp;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  rp;
    logic        ui;
    logic        wp;
    logic [5:0]  ctl;
  } instr_t;

  // reference model state
  int          md_prog = 0;
  int          acc_cnt = 0;
  logic [5:0]  e_ctl   = '0;
  logic [31:0] e_pcb   = '0;
  logic [31:0] e_alu   = '0;
  logic [31:0] e_dt    = '0;
  logic        e_zero  = 1'b0;
  logic [4:0]  e_ra    = '0;
  logic [31:0] m_a;
  logic [31:0] m_fb;
  logic [31:0] m_b;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic [63:0]        p;
    int                 s;
    sa = a;
    s  = int'(b & 32'd31);
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return a << s;
      4'd8:  return a >> s;
      4'd9:  return sa >>> s;
      4'd10: return b << 16;
`ifdef EX_MULDIV_EN
      4'd12: return p[31:0];
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                     input logic [31:0] src);
    if (ex.write_probe && r != 0 && ex.reg_probe == r)
      return ex.data_probe;
    return src;
  endfunction

  function automatic bit exp_stall();
    return !reset && MD_ON && ex.alu_op >= 4'd12 &&
           ex.alu_op <= 4'd14 && md_prog < MD_CYC;
  endfunction

  // instruction-level model: a mul/div holds for MD_CYC enabled edges,
  // then its result loads like any single-cycle op
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_prog = 0;
      e_ctl   = '0;
      e_pcb   = '0;
      e_alu   = '0;
      e_dt    = '0;
      e_zero  = 1'b0;
      e_ra    = '0;
    end else if (ex.we) begin
      if (exp_stall()) begin
        md_prog++;
        e_ctl = '0;
      end else begin
        m_a    = fwd(ex.rs_addr, ex.src_a);
        m_fb   = fwd(ex.rt_addr, ex.src_b);
        m_b    = ex.use_imm ? ex.imm : m_fb;
        e_alu  = ref_alu(ex.alu_op, m_a, m_b);
        e_zero = (e_alu == 32'd0);
        e_pcb  = ex.pc_next + ex.imm * 32'd4;
        e_dt   = m_fb;
        e_ra   = ex.reg_addr_in;
        e_ctl  = {ex.is_branch_in, ex.mem_read_in,
                  ex.mem_write_in, ex.mem_type_in,
                  ex.mem_to_reg_in, ex.reg_write_in};
        md_prog = 0;
        acc_cnt++;
      end
    end
  end

  // compare every output against the model each cycle
  always @(negedge clk) begin
    chk("stall", 32'(ex.stall), 32'(exp_stall()));
    chk("ctl", 32'({ex.is_branch, ex.mem_read, ex.mem_write,
                    ex.mem_type, ex.mem_to_reg, ex.reg_write}),
        32'(e_ctl));
    chk("alu_out", ex.alu_out, e_alu);
    chk("alu_zero", 32'(ex.alu_zero), 32'(e_zero));
    chk("pc_branch", ex.pc_branch, e_pcb);
    chk("data_t", ex.data_t, e_dt);
    chk("reg_addr", 32'(ex.reg_addr), 32'(e_ra));
  end

  function automatic instr_t mk(input logic [3:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    instr_t i;
    i.op  = op;
    i.a   = a;
    i.b   = b;
    i.imm = 32'd0;
    i.pcn = 32'd0;
    i.dp  = 32'd0;
    i.rs  = 5'd0;
    i.rt  = 5'd0;
    i.rd  = 5'd1;
    i.rp  = 5'd0;
    i.ui  = 1'b0;
    i.wp  = 1'b0;
    i.ctl = 6'b000001;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex.alu_op        = i.op;
    ex.src_a         = i.a;
    ex.src_b         = i.b;
    ex.imm           = i.imm;
    ex.pc_next       = i.pcn;
    ex.data_probe    = i.dp;
    ex.rs_addr       = i.rs;
    ex.rt_addr       = i.rt;
    ex.reg_addr_in   = i.rd;
    ex.reg_probe     = i.rp;
    ex.use_imm       = i.ui;
    ex.write_probe   = i.wp;
    ex.is_branch_in  = i.ctl[5];
    ex.mem_read_in   = i.ctl[4];
    ex.mem_write_in  = i.ctl[3];
    ex.mem_type_in   = i.ctl[2];
    ex.mem_to_reg_in = i.ctl[1];
    ex.reg_write_in  = i.ctl[0];
  endtask

  // hold an instruction until the model accepts it; count DUT stall cycles
  task automatic issue(input instr_t i, input int fz_at,
                       input int fz_len, input bit rnd_we,
                       output int nstall, output int ncyc);
    int start;
    drive(i);
    start  = acc_cnt;
    nstall = 0;
    ncyc   = 0;
    while (acc_cnt == start && ncyc < 200) begin
      if (rnd_we)
        ex.we = ($urandom_range(0, 3) != 0);
      else
        ex.we = !(ncyc >= fz_at && ncyc < fz_at + fz_len);
      @(negedge clk);
      if (ex.stall === 1'b1) nstall++;
      @(posedge clk);
      #2;
      ncyc++;
    end
    chk("accepted", 32'(acc_cnt != start), 32'd1);
    ex.we = 1'b1;
  endtask

  initial begin
    instr_t i;
    int     ns;
    int     nc;
    drive(mk(4'd0, 32'd0, 32'd0));
    ex.we = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_alu_out", ex.alu_out, 32'd0);
    chk("rst_stall", 32'(ex.stall), 32'd0);
    chk("rst_reg_write", 32'(ex.reg_write), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    issue(mk(4'd0, 32'd5, 32'd7), 99, 0, 1'b0, ns, nc);
    chk("add_5_7", ex.alu_out, 32'd12);
    chk("add_zero", 32'(ex.alu_zero), 32'd0);
    chk("add_latency", 32'(nc), 32'd1);

    i = mk(4'd1, 32'h55, 32'h55);
    i.pcn = 32'h100;
    i.imm = 32'd4;
    i.ctl = 6'b100000;
    issue(i, 99, 0, 1'b0, ns, nc);
    chk("sub_zero", 32'(ex.alu_zero), 32'd1);
    chk("sub_pc_branch", ex.pc_branch, 32'h110);
    chk("sub_is_branch", 32'(ex.is_branch), 32'd1);

    i = mk(4'd0, 32'd1, 32'd0);
    i.rs = 5'd3;
    i.rp = 5'd3;
    i.wp = 1'b1;
    i.dp = 32'hDEAD;
    issue(i, 99, 0, 1'b0, ns, nc);
    chk("fwd_rs3", ex.alu_out, 32'hDEAD);
    i.rs = 5'd0;
    i.rp = 5'd0;
    issue(i, 99, 0, 1'b0, ns, nc);
    chk("fwd_r0", ex.alu_out, 32'd1);

`ifdef EX_MULDIV_EN
    issue(mk(4'd12, 32'd1234, 32'd5678), 99, 0, 1'b0, ns, nc);
    chk("mul_stall_cycles", 32'(ns), 32'd33);
    chk("mul_result", ex.alu_out, 32'd7006652);
    chk("mul_reg_write", 32'(ex.reg_write), 32'd1);
    issue(mk(4'd13, 32'd100, 32'd7), 99, 0, 1'b0, ns, nc);
    chk("divu_100_7", ex.alu_out, 32'd14);
    issue(mk(4'd14, 32'd100, 32'd7), 99, 0, 1'b0, ns, nc);
    chk("remu_100_7", ex.alu_out, 32'd2);
    issue(mk(4'd13, 32'd9, 32'd0), 99, 0, 1'b0, ns, nc);
    chk("divu_by_0", ex.alu_out, 32'hFFFF_FFFF);
    issue(mk(4'd14, 32'd9, 32'd0), 99, 0, 1'b0, ns, nc);
    chk("remu_by_0", ex.alu_out, 32'd9);
    issue(mk(4'd12, 32'd1000, 32'd1000), 5, 4, 1'b0, ns, nc);
    chk("mul_freeze_stall", 32'(ns), 32'd37);
    chk("mul_freeze_res", ex.alu_out, 32'd1000000);
`else
    issue(mk(4'd12, 32'd1234, 32'd5678), 99, 0, 1'b0, ns, nc);
    chk("mul_off_stall", 32'(ns), 32'd0);
    chk("mul_off_result", ex.alu_out, 32'd0);
`endif

    // reset in the middle of an iterative op
    issue(mk(4'd0, 32'd40, 32'd2), 99, 0, 1'b0, ns, nc);
    drive(mk(4'd12, 32'd77, 32'd3));
    ex.we = 1'b1;
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_stall", 32'(ex.stall), 32'd0);
    chk("abort_alu_out", ex.alu_out, 32'd0);
    chk("abort_reg_write", 32'(ex.reg_write), 32'd0);
    drive(mk(4'd0, 32'd2, 32'd2));
    @(posedge clk);
    #2 reset = 1'b0;
    issue(mk(4'd0, 32'd2, 32'd2), 99, 0, 1'b0, ns, nc);
    chk("post_abort_add", ex.alu_out, 32'd4);

    for (int k = 0; k < 300; k++) begin
      i.op = 4'($urandom_range(0, 15));
      if (i.op >= 4'd12 && i.op <= 4'd14 &&
          $urandom_range(0, 2) != 0)
        i.op = 4'($urandom_range(0, 10));
      i.a   = ($urandom_range(0, 3) == 0) ?
              32'($urandom_range(0, 300)) : $urandom;
      i.b   = ($urandom_range(0, 3) == 0) ?
              32'($urandom_range(0, 20)) : $urandom;
      i.imm = ($urandom_range(0, 1) == 0) ?
              32'($urandom_range(0, 40)) : $urandom;
      i.pcn = $urandom;
      i.dp  = $urandom;
      i.rs  = 5'($urandom_range(0, 7));
      i.rt  = 5'($urandom_range(0, 7));
      i.rp  = 5'($urandom_range(0, 7));
      i.rd  = 5'($urandom_range(0, 31));
      i.ui  = 1'($urandom_range(0, 1));
      i.wp  = 1'($urandom_range(0, 1));
      i.ctl = 6'($urandom_range(0, 63));
      issue(i, 99, 0, 1'($urandom_range(0, 1)), ns, nc);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
